// File: rtl/pipelined_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_control_unit
//  Purpose  : Single-issue instruction decoder with registered control
//             strobes, latched compare flags and a multi-cycle hold for
//             memory reads.
//  Revision : 1.0  initial release
// ============================================================================
module pipelined_control_unit #(
  parameter int IW      = 9,
  parameter int SHAMT_W = 5,
  parameter int LUT_W   = 4,
  parameter int MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [IW-1:0]      instr,
  input  logic               cmp_eq,
  input  logic               cmp_lt,
  output logic               instr_ready,
  output logic               dec_valid,
  output logic               reg_write,
  output logic               mem_write,
  output logic               mem_read,
  output logic               branch_en,
  output logic               shift_en,
  output logic               lut_en,
  output logic               illegal,
  output logic [2:0]         alu_op,
  output logic               shift_dir,
  output logic [SHAMT_W-1:0] shift_amt,
  output logic [LUT_W-1:0]   lut_index,
  output logic               flag_eq,
  output logic               flag_lt
);

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

  typedef enum logic [0:0] {S_RUN = 1'b0, S_WAIT = 1'b1} state_t;

  typedef struct packed {
    logic               dec_valid;
    logic               reg_write;
    logic               mem_write;
    logic               mem_read;
    logic               branch_en;
    logic               shift_en;
    logic               lut_en;
    logic               illegal;
    logic [2:0]         alu_op;
    logic               shift_dir;
    logic [SHAMT_W-1:0] shift_amt;
    logic [LUT_W-1:0]   lut_index;
  } ctrl_t;

  state_t             state, state_nx;
  logic [3:0]         cnt, cnt_nx;
  logic               pend_wr, pend_wr_nx;
  ctrl_t              ctrl, ctrl_nx;
  logic               flag_eq_nx, flag_lt_nx;
  logic               sh_en, is_rd, rd_wr;

  logic [1:0]         itype;
  logic [2:0]         sub3;
  logic [1:0]         sub2;
  logic [3:0]         funct;

  assign itype = instr[IW-1:IW-2];
  assign sub3  = instr[IW-3:IW-5];
  assign sub2  = instr[IW-3:IW-4];
  assign funct = instr[3:0];

  assign instr_ready = (state == S_RUN);
  assign dec_valid   = ctrl.dec_valid;
  assign reg_write   = ctrl.reg_write;
  assign mem_write   = ctrl.mem_write;
  assign mem_read    = ctrl.mem_read;
  assign branch_en   = ctrl.branch_en;
  assign shift_en    = ctrl.shift_en;
  assign lut_en      = ctrl.lut_en;
  assign illegal     = ctrl.illegal;
  assign alu_op      = ctrl.alu_op;
  assign shift_dir   = ctrl.shift_dir;
  assign shift_amt   = ctrl.shift_amt;
  assign lut_index   = ctrl.lut_index;

  // State, counter, control outputs and flags; reset discards any same-cycle accept
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_RUN;
      cnt     <= '0;
      pend_wr <= 1'b0;
      ctrl    <= '0;
      flag_eq <= 1'b0;
      flag_lt <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      pend_wr <= pend_wr_nx;
      ctrl    <= ctrl_nx;
      flag_eq <= flag_eq_nx;
      flag_lt <= flag_lt_nx;
    end
  end

  // Decode the accepted instruction, or sequence the held memory read
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    pend_wr_nx = pend_wr;
    ctrl_nx    = '0;
    flag_eq_nx = flag_eq;
    flag_lt_nx = flag_lt;
    sh_en      = 1'b0;
    is_rd      = 1'b0;
    rd_wr      = 1'b0;

    if (state == S_WAIT) begin
      // Keep the read's fields steady; completion strobes only on the last cycle
      ctrl_nx           = ctrl;
      ctrl_nx.dec_valid = 1'b0;
      ctrl_nx.reg_write = 1'b0;
      if (cnt <= 4'd1) begin
        state_nx          = S_RUN;
        cnt_nx            = '0;
        ctrl_nx.dec_valid = 1'b1;
        ctrl_nx.reg_write = pend_wr;
      end else begin
        cnt_nx = cnt - 4'd1;
      end
    end else if (instr_valid) begin
      ctrl_nx.dec_valid = 1'b1;
      case (itype)
        2'b00: begin
          if (funct <= 4'd4) begin
            ctrl_nx.alu_op    = sub3;
            ctrl_nx.reg_write = 1'b1;
          end else if (funct <= 4'd7) begin
            ctrl_nx.alu_op = sub3;
            case (funct)
              4'd5: begin flag_eq_nx = 1'b0;   flag_lt_nx = cmp_lt;          end
              4'd6: begin flag_eq_nx = cmp_eq; flag_lt_nx = cmp_lt | cmp_eq; end
              default: begin flag_eq_nx = cmp_eq; flag_lt_nx = 1'b0;         end
            endcase
          end else begin
            ctrl_nx.illegal = 1'b1;
          end
        end
        2'b01: begin
          case (sub3)
            3'd0: ctrl_nx.mem_write = 1'b1;
            3'd1, 3'd6: begin
              ctrl_nx.mem_read  = 1'b1;
              ctrl_nx.reg_write = 1'b1;
              is_rd             = 1'b1;
              rd_wr             = 1'b1;
            end
            3'd2, 3'd3: begin
              ctrl_nx.mem_read  = 1'b1;
              ctrl_nx.lut_en    = 1'b1;
              ctrl_nx.lut_index = instr[LUT_W-1:0];
              is_rd             = 1'b1;
            end
            3'd4, 3'd5: begin
              ctrl_nx.reg_write = 1'b1;
              ctrl_nx.lut_index = instr[LUT_W-1:0];
            end
            default: ctrl_nx.illegal = 1'b1;
          endcase
        end
        2'b10: begin
          case (sub2)
            2'd0:    ctrl_nx.branch_en = flag_eq;
            2'd1:    ctrl_nx.branch_en = flag_lt;
            2'd2:    ctrl_nx.branch_en = flag_eq | flag_lt;
            default: ctrl_nx.branch_en = 1'b1;
          endcase
        end
        default: begin
          case (sub2)
            2'd2:    sh_en = flag_eq;
            2'd3:    sh_en = flag_lt;
            default: sh_en = 1'b1;
          endcase
          if (sh_en) begin
            ctrl_nx.shift_en  = 1'b1;
            ctrl_nx.reg_write = 1'b1;
            ctrl_nx.shift_dir = sub2[0];
            ctrl_nx.shift_amt = instr[SHAMT_W-1:0];
          end
        end
      endcase

      // Memory reads with latency park in WAIT and defer completion
      if (is_rd && (MEM_LAT != 0)) begin
        ctrl_nx.dec_valid = 1'b0;
        ctrl_nx.reg_write = 1'b0;
        pend_wr_nx        = rd_wr;
        cnt_nx            = LAT_INIT;
        state_nx          = S_WAIT;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipelined_control_unit
//  Purpose  : Scoreboard bench for pipelined_control_unit with directed and
//             random instruction streams and a per-cycle output monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipelined_control_unit;

  localparam int IW      = 9;
  localparam int SHAMT_W = 5;
  localparam int LUT_W   = 4;
  localparam int MEM_LAT = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic               instr_valid;
  logic [IW-1:0]      instr;
  logic               cmp_eq, cmp_lt;
  logic               instr_ready, dec_valid;
  logic               reg_write, mem_write, mem_read, branch_en, shift_en, lut_en, illegal;
  logic [2:0]         alu_op;
  logic               shift_dir;
  logic [SHAMT_W-1:0] shift_amt;
  logic [LUT_W-1:0]   lut_index;
  logic               flag_eq, flag_lt;

  pipelined_control_unit #(
    .IW(IW), .SHAMT_W(SHAMT_W), .LUT_W(LUT_W), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .cmp_eq(cmp_eq), .cmp_lt(cmp_lt), .instr_ready(instr_ready),
    .dec_valid(dec_valid), .reg_write(reg_write), .mem_write(mem_write),
    .mem_read(mem_read), .branch_en(branch_en), .shift_en(shift_en),
    .lut_en(lut_en), .illegal(illegal), .alu_op(alu_op), .shift_dir(shift_dir),
    .shift_amt(shift_amt), .lut_index(lut_index), .flag_eq(flag_eq), .flag_lt(flag_lt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic               reg_write;
    logic               mem_write;
    logic               mem_read;
    logic               branch_en;
    logic               shift_en;
    logic               lut_en;
    logic               illegal;
    logic [2:0]         alu_op;
    logic               shift_dir;
    logic [SHAMT_W-1:0] shift_amt;
    logic [LUT_W-1:0]   lut_index;
    logic               flag_eq;
    logic               flag_lt;
  } exp_t;

  exp_t q[$];      // expected completion record per accepted instruction
  int   hq[$];     // held (not-yet-complete) cycles still owed by that instruction
  int   total = 0;
  int   bad   = 0;
  logic m_eq = 1'b0, m_lt = 1'b0;   // reference flags
  bit   mon_en = 1'b0;

  exp_t mon_exp, mon_act;
  logic mon_edv, mon_erdy;

  function automatic exp_t sample_outputs();
    return {reg_write, mem_write, mem_read, branch_en, shift_en, lut_en, illegal,
            alu_op, shift_dir, shift_amt, lut_index, flag_eq, flag_lt};
  endfunction

  // Reference model: derive the completion record from the instruction rules
  function automatic void model_push(input logic [IW-1:0] ins, input logic ceq, input logic clt);
    exp_t       e;
    int         hold;
    logic [1:0] ty;
    logic [2:0] s3;
    logic [1:0] s2;
    int         fn;
    bit         take;
    e    = '0;
    hold = 0;
    ty   = ins[IW-1 -: 2];
    s3   = ins[IW-3 -: 3];
    s2   = ins[IW-3 -: 2];
    fn   = int'(ins[3:0]);
    if (ty == 2'b00) begin
      if (fn >= 8) e.illegal = 1'b1;
      else begin
        e.alu_op    = s3;
        e.reg_write = (fn <= 4);
        if (fn == 5) begin m_eq = 1'b0; m_lt = clt;       end
        if (fn == 6) begin m_eq = ceq;  m_lt = clt | ceq; end
        if (fn == 7) begin m_eq = ceq;  m_lt = 1'b0;      end
      end
    end else if (ty == 2'b01) begin
      if (s3 == 3'd7) e.illegal = 1'b1;
      else begin
        e.mem_write = (s3 == 3'd0);
        e.mem_read  = s3 inside {3'd1, 3'd2, 3'd3, 3'd6};
        e.reg_write = s3 inside {3'd1, 3'd4, 3'd5, 3'd6};
        e.lut_en    = s3 inside {3'd2, 3'd3};
        if (s3 inside {[3'd2:3'd5]}) e.lut_index = ins[LUT_W-1:0];
        if (e.mem_read) hold = MEM_LAT;
      end
    end else if (ty == 2'b10) begin
      e.branch_en = (s2 == 2'd0) ? m_eq : (s2 == 2'd1) ? m_lt :
                    (s2 == 2'd2) ? (m_eq | m_lt) : 1'b1;
    end else begin
      take = (s2 < 2'd2) || (s2 == 2'd2 && m_eq) || (s2 == 2'd3 && m_lt);
      if (take) begin
        e.shift_en  = 1'b1;
        e.reg_write = 1'b1;
        e.shift_dir = (s2 == 2'd1) || (s2 == 2'd3);
        e.shift_amt = ins[SHAMT_W-1:0];
      end
    end
    e.flag_eq = m_eq;
    e.flag_lt = m_lt;
    q.push_back(e);
    hq.push_back(hold);
  endfunction

  // Monitor: every cycle, compare the DUT against idle, held or completion expectations
  always @(negedge clk) begin
    if (mon_en) begin
      mon_act = sample_outputs();
      if (q.size() > 0 && hq[0] > 0) begin
        mon_exp           = q[0];
        mon_exp.reg_write = 1'b0;
        mon_edv           = 1'b0;
        mon_erdy          = 1'b0;
        hq[0]             = hq[0] - 1;
      end else if (q.size() > 0) begin
        mon_exp  = q.pop_front();
        void'(hq.pop_front());
        mon_edv  = 1'b1;
        mon_erdy = 1'b1;
      end else begin
        mon_exp         = '0;
        mon_exp.flag_eq = m_eq;
        mon_exp.flag_lt = m_lt;
        mon_edv         = 1'b0;
        mon_erdy        = 1'b1;
      end
      total++;
      if ({dec_valid, instr_ready, mon_act} !== {mon_edv, mon_erdy, mon_exp}) begin
        bad++;
        $display("FAIL cycle_check t=%0t got dv=%b rdy=%b out=%h expected dv=%b rdy=%b out=%h",
                 $time, dec_valid, instr_ready, mon_act, mon_edv, mon_erdy, mon_exp);
      end
    end
  end

  task automatic check_reset_state(input string name);
    @(negedge clk);
    total++;
    if ({dec_valid, instr_ready, sample_outputs()} !== {1'b0, 1'b1, exp_t'('0)}) begin
      bad++;
      $display("FAIL %s got dv=%b rdy=%b out=%h expected dv=0 rdy=1 out=0",
               name, dec_valid, instr_ready, sample_outputs());
    end
  endtask

  // Present an instruction until accepted; record it at the accepting edge
  task automatic issue(input logic [IW-1:0] ins, input logic ceq, input logic clt);
    int guard;
    guard       = 0;
    instr_valid = 1'b1;
    instr       = ins;
    cmp_eq      = ceq;
    cmp_lt      = clt;
    while (!instr_ready) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 40) begin
        total++;
        bad++;
        $display("FAIL ready_timeout got instr_ready=0 expected 1 within 40 cycles");
        instr_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    model_push(ins, ceq, clt);
    instr_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a valid ADD pending: that accept must be discarded
    reset       = 1'b1;
    instr_valid = 1'b1;
    instr       = {2'b00, 3'b011, 4'd3};
    cmp_eq      = 1'b0;
    cmp_lt      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset       = 1'b0;
    instr_valid = 1'b0;
    check_reset_state("reset_state");
    @(posedge clk); #1;
    mon_en = 1'b1;

    // ADD, then quiet
    issue({2'b00, 3'b011, 4'd3}, 1'b0, 1'b0);
    idle(2);
    // SLT (lt=1) -> BLT back to back, then BEQ
    issue({2'b00, 3'b000, 4'd5}, 1'b0, 1'b1);
    issue({2'b10, 2'b01, 5'd0},  1'b0, 1'b0);
    issue({2'b10, 2'b00, 5'd0},  1'b0, 1'b0);
    // LSI gated off, EQ sets flag_eq, LSI enabled
    issue({2'b11, 2'b10, 5'd13}, 1'b0, 1'b0);
    issue({2'b00, 3'b000, 4'd7}, 1'b1, 1'b0);
    issue({2'b11, 2'b10, 5'd13}, 1'b0, 1'b0);
    // Illegal forms leave flags alone
    issue({2'b01, 3'b111, 4'd0}, 1'b0, 1'b1);
    issue({2'b00, 3'b010, 4'd9}, 1'b1, 1'b1);
    // Load byte, then an ADD presented during the wait
    issue({2'b01, 3'b001, 4'd0}, 1'b0, 1'b0);
    issue({2'b00, 3'b001, 4'd0}, 1'b0, 1'b0);
    // LUT load, load-immediate, store, RSI, unconditional branch
    issue({2'b01, 3'b010, 4'd6}, 1'b0, 1'b0);
    issue({2'b01, 3'b101, 4'd9}, 1'b0, 1'b0);
    issue({2'b01, 3'b000, 4'd2}, 1'b0, 1'b0);
    issue({2'b11, 2'b11, 5'd7},  1'b0, 1'b0);
    issue({2'b10, 2'b11, 5'd0},  1'b0, 1'b0);
    idle(1);

    // SLTE sets both flags, start a load, reset in its second wait cycle
    issue({2'b00, 3'b100, 4'd6}, 1'b1, 1'b0);
    issue({2'b01, 3'b001, 4'd0}, 1'b0, 1'b0);
    @(posedge clk); #1;
    mon_en      = 1'b0;
    reset       = 1'b1;
    instr_valid = 1'b1;
    instr       = {2'b00, 3'b011, 4'd3};
    @(posedge clk); #1;
    reset       = 1'b0;
    instr_valid = 1'b0;
    q.delete();
    hq.delete();
    m_eq = 1'b0;
    m_lt = 1'b0;
    check_reset_state("reset_mid_wait");
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Random stream with gaps
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      issue(IW'($urandom), 1'($urandom), 1'($urandom));
    end
    idle(6);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d expected 0", q.size());
    end
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_control_unit.md
PIPELINED_CONTROL_UNIT -- requirements
Module: pipelined_control_unit

Interface
REQ-001 SHALL have parameter IW, default 9, instruction width (IW >= 9).
REQ-002 SHALL have parameter SHAMT_W, default 5, shift-amount field width (SHAMT_W <= IW-4).
REQ-003 SHALL have parameter LUT_W, default 4, LUT index width (LUT_W <= IW-5).
REQ-004 SHALL have parameter MEM_LAT, default 1, memory-read wait cycles (0..15).
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk, reset.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 instr_valid  in  1  instr is presented.
REQ-009 instr  in  IW  instruction word.
REQ-010 cmp_eq, cmp_lt  in  1 each  ALU compare results, valid in the instr's cycle.
REQ-011 instr_ready  out  1  block can accept instr this cycle.
REQ-012 dec_valid  out  1  decoded instruction completes this cycle.
REQ-013 reg_write, mem_write, mem_read, branch_en, shift_en, lut_en, illegal  out  1 each  control strobes.
REQ-014 alu_op  out  3; shift_dir  out  1; shift_amt  out  SHAMT_W; lut_index  out  LUT_W.
REQ-015 flag_eq, flag_lt  out  1 each  latched compare flags.

Function
REQ-016 Fields: type=instr[IW-1:IW-2] (R=00, M=01, B=10, S=11); sub3=instr[IW-3:IW-5]; sub2=instr[IW-3:IW-4]; funct=instr[3:0]; lut field=instr[LUT_W-1:0]; shamt=instr[SHAMT_W-1:0].
REQ-017 Accept = instr_valid && instr_ready; decoded outputs registered, visible the cycle after accept (latency 1).
REQ-018 States RUN, WAIT; instr_ready=1 in RUN, 0 in WAIT.
REQ-019 R: alu_op=sub3; funct 0-4 (AND/OR/XOR/ADD/SUB) reg_write=1; funct 5-7 (SLT/SLTE/EQ) compare, no write; funct 8-15 illegal.
REQ-020 Compare accept updates flags at that edge: SLT {eq,lt}<={0,cmp_lt}; SLTE {cmp_eq,cmp_lt|cmp_eq}; EQ {cmp_eq,0}; other instructions hold flags.
REQ-021 M sub3: 0 store mem_write; 1 load byte mem_read+reg_write; 2,3 LUT load mem_read+lut_en+lut_index; 4,5 load-imm reg_write+lut_index; 6 LUT memory load mem_read+reg_write; 7 illegal.
REQ-022 B sub2: 0 BEQ branch_en=flag_eq; 1 BLT flag_lt; 2 BLTE flag_eq|flag_lt; 3 unconditional; flags sampled after any same-edge update (back-to-back compare->branch sees new flags).
REQ-023 S sub2: 0 LSL, 1 LSR unconditional; 2 LSI gated by flag_eq; 3 RSI gated by flag_lt; when enabled shift_en=1, reg_write=1, shift_dir=0 left/1 right, shift_amt=shamt; when gate false all S strobes 0, dec_valid still 1.
REQ-024 Illegal: illegal=1, dec_valid=1, all other strobes 0, flags unchanged.
REQ-025 Memory-read class (M sub3 1,2,3,6) with MEM_LAT>0: enter WAIT, counter=MEM_LAT; fields and mem_read/lut_en held MEM_LAT+1 cycles; dec_valid and reg_write asserted only on the final held cycle; return to RUN after it.
REQ-026 MEM_LAT=0: memory-read class completes in one cycle like others.
REQ-027 In cycles with dec_valid=0 outside a held memory read, all strobes, alu_op, shift_dir, shift_amt, lut_index SHALL be 0.
REQ-028 instr_valid in WAIT is ignored; no instruction lost (source holds under !instr_ready).

Reset
REQ-029 reset SHALL force RUN, counter 0, flag_eq=flag_lt=0, all outputs 0 except instr_ready=1, at the next edge, including mid-WAIT.
REQ-030 Accept in the cycle reset is high SHALL be discarded.

Verification
REQ-031 Reset then ADD (R, funct 3) -> next cycle dec_valid=1, reg_write=1, alu_op=sub3; then all 0.
REQ-032 SLT with cmp_lt=1, next-cycle BLT -> flag_lt=1, branch_en=1 one cycle after BLT accept; BEQ same -> branch_en=0.
REQ-033 MEM_LAT=3, load byte -> instr_ready low 3 cycles, mem_read high 4, reg_write+dec_valid only on 4th.
REQ-034 LSI with flag_eq=0 -> dec_valid=1, shift_en=0, reg_write=0; after EQ with cmp_eq=1 -> shift_en=1, shift_amt=shamt.
REQ-035 M sub3=7 and R funct 9 -> illegal=1, no strobes, flags unchanged.
REQ-036 reset asserted in second WAIT cycle -> next cycle instr_ready=1, all strobes 0, flags 0.
